// File: rtl/time_set_ctrl.sv
// time_set_ctrl: two-button edit front-end for the 12-hour BCD clock chain.
// key_mode steps RUN -> SET_HR -> SET_MT -> COMMIT. key_up increments the
// field being edited and auto-repeats while held. COMMIT issues a one-cycle
// load of hour, minute, AM/PM and seconds=00 into the counter chain.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int BLINK_HALF      = 12500000,
    parameter int TIMEOUT         = 500000000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic [4:0] cur_hr,
    input  logic [6:0] cur_mt,
    input  logic       cur_ap,
    output logic [4:0] set_hr,
    output logic [6:0] set_mt,
    output logic [6:0] set_sc,
    output logic       set_ap,
    output logic       load,
    output logic       setting,
    output logic       blank_hr,
    output logic       blank_mt
);

    // Counter widths sized from the parameters so small test values stay small.
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPW     = $clog2(REP_MAX + 1);
    localparam int BKW     = $clog2(BLINK_HALF + 1);
    localparam int TOW     = $clog2(TIMEOUT + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPW-1:0] REP_FIRST = RPW'(REPEAT_DELAY);
    localparam logic [RPW-1:0] REP_NEXT  = RPW'(REPEAT_RATE);
    localparam logic [BKW-1:0] BK_LAST   = BKW'(BLINK_HALF - 1);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SET_HR = 2'd1,
        ST_SET_MT = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     hr_q, hr_d;
    logic [6:0]     mt_q, mt_d;
    logic           ap_q, ap_d;

    logic [1:0]     key_raw;
    logic [1:0]     key_press;
    logic           up_level;

    logic [RPW-1:0] rep_cnt_q;
    logic           rep_phase_q;
    logic           rep_fire;

    logic [BKW-1:0] blink_cnt_q;
    logic           blink_q;
    logic [TOW-1:0] to_cnt_q;

    logic           mode_evt;
    logic           up_any_evt;
    logic           up_evt;
    logic           edit_state;
    logic           timeout_hit;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    function automatic logic hr_valid(input logic [4:0] h);
        return ((h[4] == 1'b0) && (h[3:0] >= 4'd1) && (h[3:0] <= 4'd9)) ||
               ((h[4] == 1'b1) && (h[3:0] <= 4'd2));
    endfunction

    function automatic logic mt_valid(input logic [6:0] m);
        return (m[6:4] <= 3'd5) && (m[3:0] <= 4'd9);
    endfunction

    function automatic logic [4:0] hr_inc(input logic [4:0] h);
        logic [4:0] r;
        if (h == 5'h12)
            r = 5'h01;
        else if (h[3:0] == 4'd9)
            r = 5'h10;
        else
            r = h + 5'd1;
        return r;
    endfunction

    function automatic logic [6:0] mt_inc(input logic [6:0] m);
        logic [6:0] r;
        if (m == 7'h59)
            r = 7'h00;
        else if (m[3:0] == 4'd9)
            r = {m[6:4] + 3'd1, 4'd0};
        else
            r = m + 7'd1;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Per-key synchroniser, debouncer and press detector (bit 0 = mode,
    // bit 1 = up). Buttons are active-low, so "released" is level 1.
    // ------------------------------------------------------------------
    assign key_raw = {key_up, key_mode};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic           sync1_q;
        logic           sync2_q;
        logic           level_q;
        logic           press_q;
        logic [DBW-1:0] cnt_q;

        // Two-flop sync, then accept a new level after DEBOUNCE_CYCLES
        // consecutive differing samples; a 1->0 acceptance is the press.
        always_ff @(posedge clk_50) begin
            if (!rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                level_q <= 1'b1;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= key_raw[gi];
                sync2_q <= sync1_q;
                press_q <= 1'b0;
                if (sync2_q == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_q   <= '0;
                    level_q <= sync2_q;
                    press_q <= level_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign key_press[gi] = press_q;

        if (gi == 1) begin : g_up_level
            assign up_level = level_q;
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat for key_up: first repeat REPEAT_DELAY cycles after the
    // press, then every REPEAT_RATE cycles, stopping as soon as released.
    // rep_cnt_q holds the number of cycles since the last up event.
    // ------------------------------------------------------------------
    always_comb begin
        rep_fire = 1'b0;
        if (!up_level && !key_press[1])
            rep_fire = (rep_cnt_q == (rep_phase_q ? REP_NEXT : REP_FIRST));
    end

    // Repeat interval counter; restarts on the press and on every repeat.
    always_ff @(posedge clk_50) begin
        if (!rst_n || up_level) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else if (key_press[1]) begin
            rep_cnt_q   <= RPW'(1);
            rep_phase_q <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt_q   <= RPW'(1);
            rep_phase_q <= 1'b1;
        end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
        end
    end

    // Mode has priority: an up event coinciding with mode is dropped.
    assign mode_evt    = key_press[0];
    assign up_any_evt  = key_press[1] | rep_fire;
    assign up_evt      = up_any_evt & ~mode_evt;
    assign edit_state  = (state_q == ST_SET_HR) || (state_q == ST_SET_MT);
    assign timeout_hit = (to_cnt_q == TO_LAST);

    // Idle timer for edit states; any key event restarts it.
    always_ff @(posedge clk_50) begin
        if (!rst_n || !edit_state || mode_evt || up_any_evt)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 1'b1;
    end

    // Blink toggle; held off in RUN and restarted by an up event so the
    // freshly edited value is visible at once.
    always_ff @(posedge clk_50) begin
        if (!rst_n || (state_q == ST_RUN) || up_evt) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BK_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // State and edit register update.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            hr_q    <= 5'h12;
            mt_q    <= 7'h00;
            ap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hr_q    <= hr_d;
            mt_q    <= mt_d;
            ap_q    <= ap_d;
        end
    end

    // Next-state, edit-register and output decode.
    always_comb begin
        state_d  = state_q;
        hr_d     = hr_q;
        mt_d     = mt_q;
        ap_d     = ap_q;
        load     = 1'b0;
        setting  = 1'b0;
        blank_hr = 1'b0;
        blank_mt = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_evt) begin
                    // Sanitise the captured time so edits start from a legal value.
                    hr_d    = hr_valid(cur_hr) ? cur_hr : 5'h12;
                    mt_d    = mt_valid(cur_mt) ? cur_mt : 7'h00;
                    ap_d    = cur_ap;
                    state_d = ST_SET_HR;
                end
            end
            ST_SET_HR: begin
                setting  = 1'b1;
                blank_hr = blink_q;
                if (mode_evt) begin
                    state_d = ST_SET_MT;
                end else if (up_evt) begin
                    hr_d = hr_inc(hr_q);
                    // 11 -> 12 crosses noon/midnight, as the running clock does.
                    if (hr_q == 5'h11)
                        ap_d = ~ap_q;
                end else if (timeout_hit) begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_MT: begin
                setting  = 1'b1;
                blank_mt = blink_q;
                if (mode_evt) begin
                    state_d = ST_COMMIT;
                end else if (up_evt) begin
                    mt_d = mt_inc(mt_q);
                end else if (timeout_hit) begin
                    state_d = ST_RUN;
                end
            end
            ST_COMMIT: begin
                setting = 1'b1;
                load    = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign set_hr = hr_q;
    assign set_mt = mt_q;
    assign set_ap = ap_q;
    assign set_sc = 7'h00;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl using small timing parameters.
module tb_time_set_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int BH = 8;
    localparam int TO = 200;

    logic       clk_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b1;
    logic       key_up = 1'b1;
    logic [4:0] cur_hr = 5'h12;
    logic [6:0] cur_mt = 7'h00;
    logic       cur_ap = 1'b0;
    logic [4:0] set_hr;
    logic [6:0] set_mt;
    logic [6:0] set_sc;
    logic       set_ap;
    logic       load;
    logic       setting;
    logic       blank_hr;
    logic       blank_mt;

    int checks = 0;
    int failures = 0;
    int load_seen = 0;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR),
        .BLINK_HALF(BH),
        .TIMEOUT(TO)
    ) dut (
        .clk_50(clk_50),
        .rst_n(rst_n),
        .key_mode(key_mode),
        .key_up(key_up),
        .cur_hr(cur_hr),
        .cur_mt(cur_mt),
        .cur_ap(cur_ap),
        .set_hr(set_hr),
        .set_mt(set_mt),
        .set_sc(set_sc),
        .set_ap(set_ap),
        .load(load),
        .setting(setting),
        .blank_hr(blank_hr),
        .blank_mt(blank_mt)
    );

    always #5 clk_50 = ~clk_50;

    always @(negedge clk_50) if (load === 1'b1) load_seen++;

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic press_mode();
        key_mode = 1'b0;
        repeat (8) tick();
        key_mode = 1'b1;
        repeat (8) tick();
        $display("tx: mode press -> setting=%0b hr=%h mt=%h ap=%0b", setting, set_hr, set_mt, set_ap);
    endtask

    task automatic press_up();
        key_up = 1'b0;
        repeat (8) tick();
        key_up = 1'b1;
        repeat (8) tick();
        $display("tx: up press -> hr=%h mt=%h ap=%0b", set_hr, set_mt, set_ap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load got=%0b exp=0", load); end
        checks++; if (setting !== 1'b0) begin failures++; $display("FAIL reset_setting got=%0b exp=0", setting); end
        checks++; if ({blank_hr, blank_mt} !== 2'b00) begin failures++; $display("FAIL reset_blank got=%b exp=00", {blank_hr, blank_mt}); end
        checks++; if (set_hr !== 5'h12) begin failures++; $display("FAIL reset_hr got=%h exp=12", set_hr); end
        checks++; if (set_mt !== 7'h00) begin failures++; $display("FAIL reset_mt got=%h exp=00", set_mt); end
        checks++; if (set_ap !== 1'b0) begin failures++; $display("FAIL reset_ap got=%0b exp=0", set_ap); end
        checks++; if (set_sc !== 7'h00) begin failures++; $display("FAIL reset_sc got=%h exp=00", set_sc); end
        rst_n = 1'b1;
        repeat (2) tick();
        $display("tx: reset released");
    endtask

    task automatic test_commit();
        bit found = 0;
        cur_hr = 5'h11; cur_mt = 7'h59; cur_ap = 1'b0;
        load_seen = 0;
        press_mode();
        checks++; if (setting !== 1'b1) begin failures++; $display("FAIL commit_enter_setting got=%0b exp=1", setting); end
        press_mode();
        checks++; if (setting !== 1'b1) begin failures++; $display("FAIL commit_setmt_setting got=%0b exp=1", setting); end
        key_mode = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (load === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL commit_load_seen got=0 exp=1"); end
        checks++; if ({set_hr, set_mt, set_ap} !== {5'h11, 7'h59, 1'b0}) begin
            failures++; $display("FAIL commit_values got=%h:%h ap=%0b exp=11:59 ap=0", set_hr, set_mt, set_ap);
        end
        checks++; if (set_sc !== 7'h00) begin failures++; $display("FAIL commit_sc got=%h exp=00", set_sc); end
        tick();
        checks++; if ({setting, load} !== 2'b00) begin failures++; $display("FAIL commit_after got=setting%0b load%0b exp=00", setting, load); end
        key_mode = 1'b1;
        repeat (10) tick();
        checks++; if (load_seen !== 1) begin failures++; $display("FAIL commit_single_load got=%0d exp=1", load_seen); end
        $display("tx: commit done loads=%0d", load_seen);
    endtask

    task automatic test_hour_inc();
        cur_hr = 5'h11; cur_mt = 7'h30; cur_ap = 1'b0;
        press_mode();
        checks++; if ({set_hr, set_ap} !== {5'h11, 1'b0}) begin failures++; $display("FAIL hr_capture got=%h ap=%0b exp=11 ap=0", set_hr, set_ap); end
        press_up();
        checks++; if ({set_hr, set_ap} !== {5'h12, 1'b1}) begin failures++; $display("FAIL hr_11_12 got=%h ap=%0b exp=12 ap=1", set_hr, set_ap); end
        press_up();
        checks++; if ({set_hr, set_ap} !== {5'h01, 1'b1}) begin failures++; $display("FAIL hr_12_01 got=%h ap=%0b exp=01 ap=1", set_hr, set_ap); end
        press_mode();
        press_mode();
        checks++; if (setting !== 1'b0) begin failures++; $display("FAIL hr_exit got=%0b exp=0", setting); end
    endtask

    task automatic test_capture_sanitize();
        cur_hr = 5'h13; cur_mt = 7'h61; cur_ap = 1'b1;
        press_mode();
        checks++; if ({set_hr, set_mt, set_ap} !== {5'h12, 7'h00, 1'b1}) begin
            failures++; $display("FAIL sanitize got=%h:%h ap=%0b exp=12:00 ap=1", set_hr, set_mt, set_ap);
        end
        press_mode();
        press_up();
        checks++; if ({set_hr, set_mt} !== {5'h12, 7'h01}) begin failures++; $display("FAIL min_00_01 got=%h:%h exp=12:01", set_hr, set_mt); end
        press_mode();
        cur_hr = 5'h09; cur_mt = 7'h09; cur_ap = 1'b0;
        press_mode();
        press_up();
        checks++; if ({set_hr, set_ap} !== {5'h10, 1'b0}) begin failures++; $display("FAIL hr_09_10 got=%h ap=%0b exp=10 ap=0", set_hr, set_ap); end
        press_mode();
        press_up();
        checks++; if ({set_hr, set_mt} !== {5'h10, 7'h10}) begin failures++; $display("FAIL min_09_10 got=%h:%h exp=10:10", set_hr, set_mt); end
        press_mode();
    endtask

    task automatic test_repeat();
        bit found = 0;
        logic [6:0] v;
        cur_hr = 5'h03; cur_mt = 7'h58; cur_ap = 1'b0;
        press_mode();
        press_mode();
        checks++; if (set_mt !== 7'h58) begin failures++; $display("FAIL rep_start got=%h exp=58", set_mt); end
        key_up = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (set_mt === 7'h59) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rep_press got=%h exp=59", set_mt); end
        repeat (19) tick();
        checks++; if (set_mt !== 7'h59) begin failures++; $display("FAIL rep_before_delay got=%h exp=59", set_mt); end
        tick();
        checks++; if (set_mt !== 7'h00) begin failures++; $display("FAIL rep_at_delay got=%h exp=00", set_mt); end
        repeat (4) tick();
        checks++; if (set_mt !== 7'h00) begin failures++; $display("FAIL rep_before_rate got=%h exp=00", set_mt); end
        tick();
        checks++; if (set_mt !== 7'h01) begin failures++; $display("FAIL rep_rate1 got=%h exp=01", set_mt); end
        repeat (5) tick();
        checks++; if (set_mt !== 7'h02) begin failures++; $display("FAIL rep_rate2 got=%h exp=02", set_mt); end
        checks++; if (set_hr !== 5'h03) begin failures++; $display("FAIL rep_hr_kept got=%h exp=03", set_hr); end
        repeat (3) tick();
        key_up = 1'b1;
        repeat (10) tick();
        v = set_mt;
        repeat (20) tick();
        checks++; if (set_mt !== v) begin failures++; $display("FAIL rep_release got=%h exp=%h", set_mt, v); end
        $display("tx: repeat done mt=%h", set_mt);
        press_mode();
    endtask

    task automatic test_glitch_simul();
        for (int w = 1; w <= 3; w++) begin
            key_mode = 1'b0;
            repeat (w) tick();
            key_mode = 1'b1;
            repeat (10) tick();
            checks++; if (setting !== 1'b0) begin failures++; $display("FAIL glitch_w%0d got=%0b exp=0", w, setting); end
        end
        cur_hr = 5'h07; cur_mt = 7'h20; cur_ap = 1'b0;
        press_mode();
        key_mode = 1'b0; key_up = 1'b0;
        repeat (8) tick();
        key_mode = 1'b1; key_up = 1'b1;
        repeat (8) tick();
        checks++; if ({set_hr, set_mt} !== {5'h07, 7'h20}) begin failures++; $display("FAIL simul_no_up got=%h:%h exp=07:20", set_hr, set_mt); end
        press_up();
        checks++; if ({set_hr, set_mt} !== {5'h07, 7'h21}) begin failures++; $display("FAIL simul_in_setmt got=%h:%h exp=07:21", set_hr, set_mt); end
        press_mode();
    endtask

    task automatic test_timeout();
        bit found = 0;
        cur_hr = 5'h04; cur_mt = 7'h15; cur_ap = 1'b0;
        load_seen = 0;
        key_mode = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (setting === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL to_enter got=0 exp=1"); end
        key_mode = 1'b1;
        repeat (TO - 5) tick();
        checks++; if (setting !== 1'b1) begin failures++; $display("FAIL to_early got=%0b exp=1", setting); end
        repeat (10) tick();
        checks++; if (setting !== 1'b0) begin failures++; $display("FAIL to_expired got=%0b exp=0", setting); end
        checks++; if (load_seen !== 0) begin failures++; $display("FAIL to_no_load got=%0d exp=0", load_seen); end
        checks++; if ({set_hr, set_mt} !== {5'h04, 7'h15}) begin failures++; $display("FAIL to_hold got=%h:%h exp=04:15", set_hr, set_mt); end
        $display("tx: timeout done");
    endtask

    task automatic test_reset_abort();
        cur_hr = 5'h06; cur_mt = 7'h33; cur_ap = 1'b1;
        press_mode();
        press_mode();
        checks++; if (setting !== 1'b1) begin failures++; $display("FAIL abort_pre got=%0b exp=1", setting); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if ({setting, load} !== 2'b00) begin failures++; $display("FAIL abort_ctrl got=%b exp=00", {setting, load}); end
        checks++; if ({set_hr, set_mt} !== {5'h12, 7'h00}) begin failures++; $display("FAIL abort_vals got=%h:%h exp=12:00", set_hr, set_mt); end
        repeat (3) tick();
        checks++; if (setting !== 1'b0) begin failures++; $display("FAIL abort_stay got=%0b exp=0", setting); end
        $display("tx: reset abort done");
    endtask

    task automatic test_blink();
        bit found = 0;
        cur_hr = 5'h02; cur_mt = 7'h10; cur_ap = 1'b0;
        key_mode = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (setting === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL blink_enter got=0 exp=1"); end
        key_mode = 1'b1;
        checks++; if (blank_hr !== 1'b0) begin failures++; $display("FAIL blink_t0 got=%0b exp=0", blank_hr); end
        repeat (7) tick();
        checks++; if (blank_hr !== 1'b0) begin failures++; $display("FAIL blink_t7 got=%0b exp=0", blank_hr); end
        tick();
        checks++; if (blank_hr !== 1'b1) begin failures++; $display("FAIL blink_t8 got=%0b exp=1", blank_hr); end
        checks++; if (blank_mt !== 1'b0) begin failures++; $display("FAIL blink_mt_t8 got=%0b exp=0", blank_mt); end
        repeat (7) tick();
        checks++; if (blank_hr !== 1'b1) begin failures++; $display("FAIL blink_t15 got=%0b exp=1", blank_hr); end
        tick();
        checks++; if (blank_hr !== 1'b0) begin failures++; $display("FAIL blink_t16 got=%0b exp=0", blank_hr); end
        found = 0;
        key_up = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (set_hr === 5'h03) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL blink_up got=%h exp=03", set_hr); end
        key_up = 1'b1;
        checks++; if (blank_hr !== 1'b0) begin failures++; $display("FAIL blink_up_clear got=%0b exp=0", blank_hr); end
        repeat (7) tick();
        checks++; if (blank_hr !== 1'b0) begin failures++; $display("FAIL blink_up_t7 got=%0b exp=0", blank_hr); end
        tick();
        checks++; if (blank_hr !== 1'b1) begin failures++; $display("FAIL blink_up_t8 got=%0b exp=1", blank_hr); end
        $display("tx: blink done");
        repeat (8) tick();
        press_mode();
        press_mode();
    endtask

    initial begin
        test_reset();
        test_commit();
        test_hour_inc();
        test_capture_sanitize();
        test_repeat();
        test_glitch_simul();
        test_timeout();
        test_reset_abort();
        test_blink();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
